sar_seq: RTL and testbench
==========================

# sar_seq

Parametrised successive-approximation sequencer for the SAR ADC. It closes the loop around the analog frontend. It drives the channel select, sample/hold and the DAC code, samples the comparator output, and resolves one N-bit code per conversion. Single-channel and multi-channel scan modes are supported, and results are delivered on a valid/ready stream. It sits between the AFE (DAC + comparator) and the digital back end.

## Interface
Parameters:
- ADC_RESOLUTION, 8, bits per conversion (≥2)
- N_CH, 4, analog input channels (≥1); CH_W = max(1, $clog2(N_CH))
- SAMPLE_CYCLES, 2, cycles o_sample is held high per conversion (≥1)
- SETTLE_CYCLES, 1, cycles per bit trial, i.e. DAC settling before the comparator is sampled (≥1)
- OSR_LOG2, 2, log2 of conversions summed per result; used only with SAR_OVERSAMPLE_EN
- DATA_W, ADC_RESOLUTION (+OSR_LOG2 with SAR_OVERSAMPLE_EN), result width (derived)

Ports:
- i_clk  in  1  single clock, all logic on posedge
- i_rst_n  in  1  synchronous, active-low reset
- i_start  in  1  start request, sampled in IDLE only
- i_mode  in  1  0 = single (channel i_ch_sel), 1 = scan (channels in i_ch_mask)
- i_ch_sel  in  CH_W  channel for single mode
- i_ch_mask  in  N_CH  enabled channels for scan mode
- i_comp  in  1  comparator: 1 = VIN > V_DAC
- o_ch  out  CH_W  channel routed to the AFE
- o_sample  out  1  track (1) / hold (0)
- o_dac_code  out  ADC_RESOLUTION  code presented to the DAC
- o_busy  out  1  sequencer not in IDLE
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_data  out  DATA_W  conversion result
- o_data_ch  out  CH_W  channel of o_data

## Operation
- States: IDLE → SAMPLE → BIT → OUT → (SAMPLE | IDLE).
- IDLE: when i_start=1, latch i_mode, i_ch_sel and i_ch_mask. In scan mode with mask==0 the start is ignored and the sequencer stays in IDLE. i_start outside IDLE is ignored.
- SAMPLE: o_sample=1 and o_ch stable for SAMPLE_CYCLES cycles. The SAR register clears to 0.
- BIT: for k = RES-1 down to 0, o_dac_code = sar | (1<<k) for SETTLE_CYCLES cycles. i_comp is sampled on the edge that ends the trial. If it is 1, bit k is kept; otherwise it is cleared. After the final trial (bit 0), o_dac_code returns to 0.
- OUT: o_valid=1 with o_data and o_data_ch stable until o_valid&&i_ready. The sequencer stalls in OUT, so no result is ever dropped.
- On acceptance in single mode, go to IDLE.
- On acceptance in scan mode, go to SAMPLE on the next set mask bit above the current one (ascending). If none remains, go to IDLE. Each start produces one sweep.
- Reset value of every output: 0 (o_ch=0, o_sample=0, o_dac_code=0, o_busy=0, o_valid=0, o_data=0, o_data_ch=0).
- Reset asserted mid-conversion returns to IDLE on that edge and discards the partial result.

## Timing
- Start edge E0 → o_sample high in cycles 1..SAMPLE_CYCLES → RES×SETTLE_CYCLES bit cycles → o_valid high in the next cycle.
- Latency from E0 to first o_valid cycle: SAMPLE_CYCLES + RES×SETTLE_CYCLES + 1 cycles. For defaults: 2+8+1 = 11.
- Scan back-to-back: the next SAMPLE begins the cycle after the acceptance edge, giving zero idle cycles when i_ready is held high.
- o_busy is high from the cycle after E0 until the cycle IDLE is re-entered.
- o_valid may rise with i_ready already high. Acceptance then completes in that same cycle.

## Configuration
- SAR_OVERSAMPLE_EN defined:
  - Each channel is converted 2^OSR_LOG2 times consecutively (SAMPLE + BIT each time).
  - Codes are summed in a DATA_W accumulator, and only the sum is presented in OUT.
  - Latency is multiplied by 2^OSR_LOG2.
- Undefined: one conversion per result, DATA_W = ADC_RESOLUTION, OSR_LOG2 ignored, no accumulator logic.

## Structure
- sar_pkg: state enum (IDLE, SAMPLE, BIT, OUT), mode enum (MODE_SINGLE, MODE_SCAN), and a next-channel helper function (lowest set mask bit above a given index).
- Sub-module sar_bit_engine: SAR register, bit pointer and settle counter. It has ports start/done, i_comp and code. sar_seq owns the FSM, channel scan, oversampling accumulator and output handshake.

## Test plan
Bench comparator model: i_comp = (vin_code[o_ch] >= o_dac_code). This yields result == vin_code.
- Single mode, RES=8, ch 2, vin_code=0xA5, i_ready=1 → o_data=0xA5, o_data_ch=2, o_valid exactly 11 cycles after the start edge.
- Bounds: vin_code=0x00 → 0x00; vin_code=0xFF → 0xFF. Check the o_dac_code sequence 0x80, 0xC0, …, 0xFF for the 0xFF case.
- Scan mode, mask=4'b1011, codes {0x11,0x22,0x33,0x44} → results in channel order 0, 1, 3 with 0x11, 0x22, 0x44; then IDLE and o_busy=0.
- Backpressure: i_ready=0 for 20 cycles in OUT → o_data stable, o_valid held, no new o_sample; release → next channel proceeds.
- Reset mid-BIT and ignored starts:
  - Deassert i_rst_n mid-BIT → all outputs 0 next cycle; a fresh start converts correctly.
  - Scan mode with mask=0 → stays IDLE.
- With SAR_OVERSAMPLE_EN, OSR_LOG2=2, vin_code=0x40 → o_data=0x100, latency 4×10+1 = 41 cycles.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR sequencer.
// SAR_OVERSAMPLE_EN selects the oversampling build (summed conversions per result).
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    BIT    = 2'd2,
    OUT    = 2'd3
  } state_e;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  // The channel search works on a fixed-width mask, so N_CH is limited to MAX_CH.
  localparam int MAX_CH = 32;
  localparam int IDX_W  = $clog2(MAX_CH);

`ifdef SAR_OVERSAMPLE_EN
  localparam bit OSR_EN = 1'b1;
`else
  localparam bit OSR_EN = 1'b0;
`endif

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } ch_pick_t;

  // Lowest set mask bit at or above 'from'; found=0 when none remains.
  function automatic ch_pick_t next_set_ch(input logic [MAX_CH-1:0] mask, input int from);
    ch_pick_t pick;
    pick = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        pick.found = 1'b1;
        pick.idx   = IDX_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation core: SAR register, bit pointer and per-trial settle counter.
// A start pulse clears the SAR; done pulses on the edge that resolves bit 0.
module sar_bit_engine #(
  parameter int RES           = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic           i_comp,
  output logic [RES-1:0] o_code,
  output logic [RES-1:0] o_result,
  output logic           o_done
);

  localparam int PTR_W = $clog2(RES);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic             active_q, active_d;
  logic [RES-1:0]   sar_q, sar_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic             trial_end;

  assign trial_end = active_q && (settle_q == SET_W'(SETTLE_CYCLES - 1));
  assign o_done    = trial_end && (ptr_q == '0);
  assign o_code    = active_q ? (sar_q | (RES'(1) << ptr_q)) : '0;
  // Includes the bit being resolved this cycle, so the caller can capture it on done.
  assign o_result  = sar_d;

  always_comb begin
    // NOTE: every next-state variable gets its default first so no path infers a latch.
    active_d = active_q;
    sar_d    = sar_q;
    ptr_d    = ptr_q;
    settle_d = settle_q;
    if (i_start) begin
      active_d = 1'b1;
      sar_d    = '0;
      ptr_d    = PTR_W'(RES - 1);
      settle_d = '0;
    end else if (active_q) begin
      if (trial_end) begin
        sar_d[ptr_q] = i_comp;
        settle_d     = '0;
        if (ptr_q == '0) begin
          active_d = 1'b0;
        end else begin
          ptr_d = ptr_q - 1'b1;
        end
      end else begin
        settle_d = settle_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      active_q <= 1'b0;
      sar_q    <= '0;
      ptr_q    <= '0;
      settle_q <= '0;
    end else begin
      active_q <= active_d;
      sar_q    <= sar_d;
      ptr_q    <= ptr_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/sar_seq.sv
// SAR ADC sequencer: channel select, sample/hold, bit trials and valid/ready result stream.
// SAR_OVERSAMPLE_EN: sum 2^OSR_LOG2 conversions per channel into a wider result.
module sar_seq
  import sar_pkg::*;
#(
  parameter int  ADC_RESOLUTION = 8,
  parameter int  N_CH           = 4,
  parameter int  SAMPLE_CYCLES  = 2,
  parameter int  SETTLE_CYCLES  = 1,
  parameter int  OSR_LOG2       = 2,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int DATA_W         = ADC_RESOLUTION + (OSR_EN ? OSR_LOG2 : 0)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic                      i_mode,
  input  logic [CH_W-1:0]           i_ch_sel,
  input  logic [N_CH-1:0]           i_ch_mask,
  input  logic                      i_comp,
  output logic [CH_W-1:0]           o_ch,
  output logic                      o_sample,
  output logic [ADC_RESOLUTION-1:0] o_dac_code,
  output logic                      o_busy,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic [CH_W-1:0]           o_data_ch
);

  localparam int SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [N_CH-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SMP_W-1:0]  smp_q, smp_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic                      eng_start;
  logic                      eng_done;
  logic [ADC_RESOLUTION-1:0] eng_result;
  ch_pick_t                  first_pick;
  ch_pick_t                  next_pick;

`ifdef SAR_OVERSAMPLE_EN
  localparam int OSR_N  = 1 << OSR_LOG2;
  localparam int CONV_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;

  logic [CONV_W-1:0] conv_q, conv_d;
  logic [DATA_W-1:0] acc_q, acc_d;
`endif

  sar_bit_engine #(
    .RES           (ADC_RESOLUTION),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_bit_engine (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (eng_start),
    .i_comp   (i_comp),
    .o_code   (o_dac_code),
    .o_result (eng_result),
    .o_done   (eng_done)
  );

  assign first_pick = next_set_ch(MAX_CH'(i_ch_mask), 0);
  assign next_pick  = next_set_ch(MAX_CH'(mask_q), int'(ch_q) + 1);

  assign o_ch      = ch_q;
  assign o_sample  = (state_q == SAMPLE);
  assign o_busy    = (state_q != IDLE);
  assign o_valid   = (state_q == OUT);
  assign o_data    = data_q;
  assign o_data_ch = ch_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    smp_d     = smp_q;
    data_d    = data_q;
    eng_start = 1'b0;
`ifdef SAR_OVERSAMPLE_EN
    conv_d    = conv_q;
    acc_d     = acc_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mode_d = mode_e'(i_mode);
          mask_d = i_ch_mask;
          smp_d  = '0;
          if (mode_e'(i_mode) == MODE_SINGLE) begin
            ch_d    = i_ch_sel;
            state_d = SAMPLE;
          end else if (first_pick.found) begin
            ch_d    = CH_W'(first_pick.idx);
            state_d = SAMPLE;
          end
        end
      end

      SAMPLE: begin
        if (smp_q == SMP_W'(SAMPLE_CYCLES - 1)) begin
          eng_start = 1'b1;
          state_d   = BIT;
        end else begin
          smp_d = smp_q + 1'b1;
        end
      end

      BIT: begin
        if (eng_done) begin
`ifdef SAR_OVERSAMPLE_EN
          if (conv_q != CONV_W'(OSR_N - 1)) begin
            acc_d   = acc_q + DATA_W'(eng_result);
            conv_d  = conv_q + 1'b1;
            smp_d   = '0;
            state_d = SAMPLE;
          end else begin
            data_d  = acc_q + DATA_W'(eng_result);
            acc_d   = '0;
            conv_d  = '0;
            state_d = OUT;
          end
`else
          data_d  = DATA_W'(eng_result);
          state_d = OUT;
`endif
        end
      end

      OUT: begin
        if (i_ready) begin
          if ((mode_q == MODE_SCAN) && next_pick.found) begin
            ch_d    = CH_W'(next_pick.idx);
            smp_d   = '0;
            state_d = SAMPLE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_SINGLE;
      mask_q  <= '0;
      ch_q    <= '0;
      smp_q   <= '0;
      data_q  <= '0;
`ifdef SAR_OVERSAMPLE_EN
      conv_q  <= '0;
      acc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
`ifdef SAR_OVERSAMPLE_EN
      conv_q  <= conv_d;
      acc_q   <= acc_d;
`endif
    end
  end

endmodule

// File: tb/tb_sar_seq.sv
// Directed bench for sar_seq with an ideal comparator: i_comp = (vin_code[o_ch] >= o_dac_code).
// Expected sums and latencies scale by the oversampling factor when SAR_OVERSAMPLE_EN is set.
module tb_sar_seq;
  import sar_pkg::*;

  localparam int RES   = 8;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int OSR_N = OSR_EN ? 4 : 1;
  localparam int DW    = RES + (OSR_EN ? 2 : 0);
  localparam int LAT   = OSR_N * (2 + RES * 1) + 1;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_mode = 1'b0;
  logic [CHW-1:0] i_ch_sel = '0;
  logic [NCH-1:0] i_ch_mask = '0;
  logic           i_ready = 1'b1;
  logic           i_comp;
  logic [CHW-1:0] o_ch;
  logic           o_sample;
  logic [RES-1:0] o_dac_code;
  logic           o_busy;
  logic           o_valid;
  logic [DW-1:0]  o_data;
  logic [CHW-1:0] o_data_ch;

  logic [RES-1:0] vin_code [NCH];
  int             n_checks = 0;
  int             n_pass = 0;

  sar_seq dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_mode     (i_mode),
    .i_ch_sel   (i_ch_sel),
    .i_ch_mask  (i_ch_mask),
    .i_comp     (i_comp),
    .o_ch       (o_ch),
    .o_sample   (o_sample),
    .o_dac_code (o_dac_code),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_data_ch  (o_data_ch)
  );

  always #5 i_clk = ~i_clk;

  assign i_comp = (vin_code[o_ch] >= o_dac_code);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_conv(input logic mode, input logic [CHW-1:0] ch, input logic [NCH-1:0] mask);
    i_start   = 1'b1;
    i_mode    = mode;
    i_ch_sel  = ch;
    i_ch_mask = mask;
    tick();
    i_start   = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ch"},      32'(o_ch),       32'd0);
    check({tag, "_sample"},  32'(o_sample),   32'd0);
    check({tag, "_dac"},     32'(o_dac_code), 32'd0);
    check({tag, "_busy"},    32'(o_busy),     32'd0);
    check({tag, "_valid"},   32'(o_valid),    32'd0);
    check({tag, "_data"},    32'(o_data),     32'd0);
    check({tag, "_data_ch"}, 32'(o_data_ch),  32'd0);
  endtask

  // Called in cycle cyc0 after the start (or acceptance) edge; waits for o_valid.
  task automatic wait_valid(input string tag, input int cyc0, input logic [31:0] exp_data,
                            input logic [31:0] exp_ch, input bit dac_chk);
    int cyc;
    cyc = cyc0;
    while (!o_valid && cyc < LAT + 20) begin
      if (dac_chk && cyc <= 10) begin
        check({tag, "_sample"}, 32'(o_sample), (cyc <= 2) ? 32'd1 : 32'd0);
        if (cyc >= 3) check({tag, "_dac"}, 32'(o_dac_code), 32'(16'hFF00 >> (cyc - 2)) & 32'hFF);
      end
      tick();
      cyc++;
    end
    check({tag, "_valid"},   32'(o_valid),   32'd1);
    check({tag, "_latency"}, 32'(cyc),       32'(LAT));
    check({tag, "_data"},    32'(o_data),    exp_data);
    check({tag, "_data_ch"}, 32'(o_data_ch), exp_ch);
  endtask

  initial begin
    int bad;
    for (int i = 0; i < NCH; i++) vin_code[i] = '0;

    i_rst_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    i_rst_n = 1'b1;
    tick();

    // Single mode, channel 2, mid-range code.
    vin_code[2] = 8'hA5;
    start_conv(1'b0, 2'd2, 4'b0000);
    wait_valid("single_a5", 1, 32'h0A5 * OSR_N, 32'd2, 1'b0);
    tick();
    check("single_a5_idle_busy", 32'(o_busy), 32'd0);
    check("single_a5_idle_valid", 32'(o_valid), 32'd0);

    // Zero code; a start pulse during the conversion must be ignored.
    vin_code[0] = 8'h00;
    start_conv(1'b0, 2'd0, 4'b0000);
    tick();
    tick();
    i_start   = 1'b1;
    i_mode    = 1'b1;
    i_ch_mask = 4'b1111;
    i_ch_sel  = 2'd2;
    tick();
    i_start   = 1'b0;
    wait_valid("single_00", 4, 32'h000, 32'd0, 1'b0);
    tick();
    check("single_00_idle_busy", 32'(o_busy), 32'd0);

    // Full-scale code with the DAC trial sequence 0x80, 0xC0, ... 0xFF.
    vin_code[1] = 8'hFF;
    start_conv(1'b0, 2'd1, 4'b0000);
    wait_valid("single_ff", 1, 32'h0FF * OSR_N, 32'd1, 1'b1);
    check("single_ff_dac_idle", 32'(o_dac_code), 32'd0);
    tick();

    vin_code[3] = 8'h40;
    start_conv(1'b0, 2'd3, 4'b0000);
    wait_valid("single_40", 1, 32'h040 * OSR_N, 32'd3, 1'b0);
    tick();

    // Scan mask 1011 with backpressure on channel 1.
    vin_code[0] = 8'h11;
    vin_code[1] = 8'h22;
    vin_code[2] = 8'h33;
    vin_code[3] = 8'h44;
    start_conv(1'b1, 2'd0, 4'b1011);
    wait_valid("scan_ch0", 1, 32'h011 * OSR_N, 32'd0, 1'b0);
    tick();
    i_ready = 1'b0;
    wait_valid("scan_ch1", 1, 32'h022 * OSR_N, 32'd1, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!o_valid || o_sample || (32'(o_data) != 32'h022 * OSR_N) || (o_data_ch != 2'd1)) bad++;
    end
    check("scan_backpressure_hold", 32'(bad), 32'd0);
    i_ready = 1'b1;
    tick();
    wait_valid("scan_ch3", 1, 32'h044 * OSR_N, 32'd3, 1'b0);
    tick();
    check("scan_end_busy", 32'(o_busy), 32'd0);
    check("scan_end_valid", 32'(o_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_busy || o_sample) bad++;
    end
    check("scan_single_sweep", 32'(bad), 32'd0);

    // Scan with an empty mask is ignored.
    start_conv(1'b1, 2'd0, 4'b0000);
    check("mask0_busy", 32'(o_busy), 32'd0);
    tick();
    tick();
    check("mask0_still_idle", 32'(o_busy | o_sample), 32'd0);

    // Reset in the middle of the bit trials, then a fresh conversion.
    start_conv(1'b0, 2'd3, 4'b0000);
    tick();
    tick();
    tick();
    tick();
    i_rst_n = 1'b0;
    tick();
    check_all_zero("rst_mid_bit");
    i_rst_n = 1'b1;
    tick();
    start_conv(1'b0, 2'd3, 4'b0000);
    wait_valid("after_rst", 1, 32'h044 * OSR_N, 32'd3, 1'b0);
    tick();
    check("after_rst_idle_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
